// File: rtl/cond_unit_if.sv
// cond_unit_if -- bus between the decode/ALU side and the condition-check stage.
//
// Signals (direction as seen by the cond_unit, i.e. the slave modport):
//   in  InstrValid       current instruction is real; 0 = bubble
//   in  Stall            hold: no flag update, no counter update
//   in  Cond[3:0]        instruction condition field
//   in  ALUFlags[3:0]    ALU flags {N,Z,C,V}
//   in  FlagW[1:0]       [1] writes N,Z; [0] writes C,V
//   in  PCS, RegW, MemW  decoder write strobes before condition gating
//   out PCSrc, RegWrite, MemWrite   gated strobes
//   out CondEx           condition passed for a live instruction
//   out Flags[3:0]       registered NZCV
//   out ExecCount, SkipCount [CNT_W-1:0]  statistics counters
//
// The master modport is the upstream driver (decoder/ALU or a testbench).
interface cond_unit_if #(
  parameter int CNT_W = 32
);
  logic             InstrValid;
  logic             Stall;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] ExecCount;
  logic [CNT_W-1:0] SkipCount;

  modport master (
    output InstrValid, Stall, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags, ExecCount, SkipCount
  );

  modport slave (
    input  InstrValid, Stall, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags, ExecCount, SkipCount
  );
endinterface

// File: rtl/cond_unit.sv
// cond_unit -- condition-check stage directly downstream of the ALU.
//
// Holds the architectural NZCV flag register, evaluates each instruction's
// condition field against the registered flags and gates the register-write,
// memory-write and PC-source strobes so skipped instructions have no side
// effects.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   synchronous, active-low reset
//   bus       cond_unit_if.slave (see the interface file for signal list)
//
// Parameters:
//   CNT_W       width of the statistics counters
//   RESET_NZCV  flag register value after reset, {N,Z,C,V}
//
// Build option: define COND_STATS_EN to keep saturating executed/skipped
// counters; without it ExecCount and SkipCount are tied to zero.
module cond_unit #(
  parameter int         CNT_W      = 32,
  parameter logic [3:0] RESET_NZCV = 4'b0000
) (
  input  logic        clk,
  input  logic        reset_n,
  cond_unit_if.slave  bus
);

  logic [3:0] flags_reg;
  logic [3:0] flags_next;
  logic       cond_pass;
  logic       cond_ex;
  logic       instr_live;

  logic n_flag, z_flag, c_flag, v_flag;
  assign {n_flag, z_flag, c_flag, v_flag} = flags_reg;

  // Decode uses only the registered flags: a flag-setting instruction is seen
  // by the next valid instruction, never by itself.
  always_comb begin
    cond_pass = 1'b0;
    case (bus.Cond)
      4'b0000: cond_pass = z_flag;
      4'b0001: cond_pass = ~z_flag;
      4'b0010: cond_pass = c_flag;
      4'b0011: cond_pass = ~c_flag;
      4'b0100: cond_pass = n_flag;
      4'b0101: cond_pass = ~n_flag;
      4'b0110: cond_pass = v_flag;
      4'b0111: cond_pass = ~v_flag;
      4'b1000: cond_pass = c_flag & ~z_flag;
      4'b1001: cond_pass = ~c_flag | z_flag;
      4'b1010: cond_pass = (n_flag == v_flag);
      4'b1011: cond_pass = (n_flag != v_flag);
      4'b1100: cond_pass = ~z_flag & (n_flag == v_flag);
      4'b1101: cond_pass = z_flag | (n_flag != v_flag);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;  // 1111 reserved: skip
    endcase
  end

  // A stalled instruction is a bubble this cycle; it will be re-presented.
  assign instr_live = bus.InstrValid & ~bus.Stall;
  assign cond_ex    = cond_pass & instr_live;

  assign bus.CondEx   = cond_ex;
  assign bus.PCSrc    = bus.PCS  & cond_ex;
  assign bus.RegWrite = bus.RegW & cond_ex;
  assign bus.MemWrite = bus.MemW & cond_ex;
  assign bus.Flags    = flags_reg;

  // FlagW[gi] owns flag pair gi: gi=1 -> {N,Z}, gi=0 -> {C,V}.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_flag_half
      assign flags_next[2*gi+1:2*gi] = (cond_ex && bus.FlagW[gi])
                                     ? bus.ALUFlags[2*gi+1:2*gi]
                                     : flags_reg[2*gi+1:2*gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags_reg <= RESET_NZCV;
    end else begin
      flags_reg <= flags_next;
    end
  end

`ifdef COND_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] exec_cnt_reg;
  logic [CNT_W-1:0] skip_cnt_reg;

  // Counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      exec_cnt_reg <= '0;
      skip_cnt_reg <= '0;
    end else if (instr_live) begin
      if (cond_ex) begin
        if (exec_cnt_reg != {CNT_W{1'b1}}) exec_cnt_reg <= exec_cnt_reg + CNT_ONE;
      end else begin
        if (skip_cnt_reg != {CNT_W{1'b1}}) skip_cnt_reg <= skip_cnt_reg + CNT_ONE;
      end
    end
  end

  assign bus.ExecCount = exec_cnt_reg;
  assign bus.SkipCount = skip_cnt_reg;
`else
  assign bus.ExecCount = {CNT_W{1'b0}};
  assign bus.SkipCount = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit -- directed-vector bench for cond_unit.
// Drives cond_unit_if from initial-block tasks, checks outputs 1 time unit
// after inputs settle (away from the rising edge) and prints one line per
// comparison plus a final summary.
module tb_cond_unit;

  localparam int CNT_W = 4;

  localparam logic [3:0] C_EQ = 4'b0000;
  localparam logic [3:0] C_NE = 4'b0001;
  localparam logic [3:0] C_GE = 4'b1010;
  localparam logic [3:0] C_LT = 4'b1011;
  localparam logic [3:0] C_GT = 4'b1100;
  localparam logic [3:0] C_LE = 4'b1101;
  localparam logic [3:0] C_AL = 4'b1110;
  localparam logic [3:0] C_NV = 4'b1111;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  cond_unit_if #(.CNT_W(CNT_W)) bus ();

  cond_unit #(.CNT_W(CNT_W), .RESET_NZCV(4'b0000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[%0t] FAIL %s got=%0h exp=%0h", $time, tag, got, exp);
    end else begin
      $display("[%0t] ok   %s got=%0h", $time, tag, got);
    end
  endtask

  // Present one instruction; outputs are allowed to settle before return.
  task automatic drive(input logic valid, input logic stall, input logic [3:0] cond,
                       input logic [3:0] alu, input logic [1:0] fw,
                       input logic pcs, input logic regw, input logic memw);
    bus.InstrValid = valid;
    bus.Stall      = stall;
    bus.Cond       = cond;
    bus.ALUFlags   = alu;
    bus.FlagW      = fw;
    bus.PCS        = pcs;
    bus.RegW       = regw;
    bus.MemW       = memw;
    #1;
    // An undefined bit on a flag half that is about to be written is a decoder error.
    if (valid && fw[1]) check_eq("xsel_nz", 32'($isunknown(alu[3:2])), 32'd0);
    if (valid && fw[0]) check_eq("xsel_cv", 32'($isunknown(alu[1:0])), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_flags(input logic [3:0] v);
    drive(1'b1, 1'b0, C_AL, v, 2'b11, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    drive(1'b0, 1'b0, C_AL, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    tick();
    tick();
    check_eq("reset_flags", 32'(bus.Flags), 32'h0);
    check_eq("reset_exec", 32'(bus.ExecCount), 32'h0);
    check_eq("reset_skip", 32'(bus.SkipCount), 32'h0);
    // Combinational path is live during reset.
    drive(1'b1, 1'b0, C_AL, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
    check_eq("reset_regwrite", 32'(bus.RegWrite), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // CMP then branch
    drive(1'b1, 1'b0, C_AL, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0);
    check_eq("cmp_condex", 32'(bus.CondEx), 32'h1);
    tick();
    check_eq("cmp_flags", 32'(bus.Flags), 32'h4);
    drive(1'b1, 1'b0, C_EQ, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0);
    check_eq("beq_pcsrc", 32'(bus.PCSrc), 32'h1);
    drive(1'b1, 1'b0, C_NE, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0);
    check_eq("bne_pcsrc", 32'(bus.PCSrc), 32'h0);
    // No same-cycle bypass: NE sees registered Z=1 although ALU reports Z=0.
    drive(1'b1, 1'b0, C_NE, 4'b0000, 2'b11, 1'b1, 1'b0, 1'b0);
    check_eq("nobypass_condex", 32'(bus.CondEx), 32'h0);
    tick();
    check_eq("nobypass_flags", 32'(bus.Flags), 32'h4);

    // Partial writes
    load_flags(4'b1111);
    drive(1'b1, 1'b0, C_AL, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("partial_nz", 32'(bus.Flags), 32'h3);
    load_flags(4'b1111);
    drive(1'b1, 1'b0, C_AL, 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("partial_cv", 32'(bus.Flags), 32'hc);

    // Skipped writer
    load_flags(4'b0000);
    drive(1'b1, 1'b0, C_EQ, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1);
    check_eq("skip_memwrite", 32'(bus.MemWrite), 32'h0);
    check_eq("skip_regwrite", 32'(bus.RegWrite), 32'h0);
    check_eq("skip_pcsrc", 32'(bus.PCSrc), 32'h0);
    tick();
    check_eq("skip_flags", 32'(bus.Flags), 32'h0);

    // Signed compares with N=1, V=0, Z=0
    load_flags(4'b1000);
    drive(1'b1, 1'b0, C_LT, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    check_eq("lt_pass", 32'(bus.CondEx), 32'h1);
    drive(1'b1, 1'b0, C_GE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    check_eq("ge_fail", 32'(bus.CondEx), 32'h0);
    drive(1'b1, 1'b0, C_GT, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    check_eq("gt_fail", 32'(bus.CondEx), 32'h0);
    drive(1'b1, 1'b0, C_LE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    check_eq("le_pass", 32'(bus.CondEx), 32'h1);
    drive(1'b1, 1'b0, C_NV, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
    check_eq("nv_condex", 32'(bus.CondEx), 32'h0);

    // Bubble and stall: no strobes, no flag update
    drive(1'b0, 1'b0, C_AL, 4'b0101, 2'b11, 1'b0, 1'b1, 1'b0);
    check_eq("bubble_regwrite", 32'(bus.RegWrite), 32'h0);
    tick();
    check_eq("bubble_flags", 32'(bus.Flags), 32'h8);
    drive(1'b1, 1'b1, C_AL, 4'b0101, 2'b11, 1'b0, 1'b1, 1'b0);
    check_eq("stall_condex", 32'(bus.CondEx), 32'h0);
    tick();
    check_eq("stall_flags", 32'(bus.Flags), 32'h8);

    // Reset wins over a simultaneous flag write
    drive(1'b1, 1'b0, C_AL, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    tick();
    check_eq("reset_wins", 32'(bus.Flags), 32'h0);
    check_eq("reset_wins_exec", 32'(bus.ExecCount), 32'h0);
    reset_n = 1'b1;

    // Statistics: 3 executed, 2 skipped, 1 stalled
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, C_AL, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, C_NV, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, C_AL, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
`ifdef COND_STATS_EN
    check_eq("stats_exec", 32'(bus.ExecCount), 32'd3);
    check_eq("stats_skip", 32'(bus.SkipCount), 32'd2);
`else
    check_eq("stats_exec_off", 32'(bus.ExecCount), 32'd0);
    check_eq("stats_skip_off", 32'(bus.SkipCount), 32'd0);
`endif
    // Drive the executed counter to all-ones and one beyond.
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 1'b0, C_AL, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
      tick();
    end
`ifdef COND_STATS_EN
    check_eq("stats_sat", 32'(bus.ExecCount), 32'hf);
    check_eq("stats_sat_skip", 32'(bus.SkipCount), 32'd2);
`else
    check_eq("stats_sat_off", 32'(bus.ExecCount), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("[%0t] FAIL watchdog got=timeout exp=finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
